// File: rtl/p_stim_driver.sv
// Command-driven stimulus/response sequencer for the formal harness wrapper.
// Packs the wrapper input word, pulses its DUT clock bit and returns the captured output word.
module p_stim_driver #(
    parameter int unsigned CLK_HALF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [16:0] cmd_data,
    input  logic [7:0]  cmd_count,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_data,
    output logic [17:0] iw,
    output logic        ena,
    input  logic [23:0] ow
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_HIGH    = 3'd2,
        ST_LOW     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_ENA    = 2'b10;
    localparam logic [1:0] OP_RSTSEQ = 2'b11;

    localparam logic [3:0] PHASE_INIT = 4'(CLK_HALF - 1);

    state_e      state_q, state_d;
    logic [17:0] iw_q, iw_d;
    logic        ena_q, ena_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [23:0] rsp_data_q, rsp_data_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rstseq_q, rstseq_d;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign iw        = iw_q;
    assign ena       = ena_q;

    // Next-state and datapath updates for the command sequencer.
    always_comb begin
        state_d     = state_q;
        iw_d        = iw_q;
        ena_d       = ena_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        rstseq_d    = rstseq_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = ST_SETTLE;
                    rstseq_d = (cmd_op == OP_RSTSEQ);
                    case (cmd_op)
                        OP_SET: begin
                            iw_d[17:1] = cmd_data;
                            cnt_d      = 8'd0;
                        end
                        OP_STEP: begin
                            iw_d[17:1] = cmd_data;
                            cnt_d      = cmd_count;
                        end
                        OP_ENA: begin
                            ena_d = cmd_data[0];
                            cnt_d = 8'd0;
                        end
                        OP_RSTSEQ: begin
                            iw_d[17:2] = cmd_data[16:1];
                            iw_d[1]    = 1'b0;
                            cnt_d      = cmd_count;
                        end
                        default: begin
                            cnt_d = 8'd0;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    state_d = ST_HIGH;
                    iw_d[0] = 1'b1;
                    phase_d = PHASE_INIT;
                end else if (rstseq_q) begin
                    state_d = ST_RELEASE;
                    iw_d[1] = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ow;
                end
            end

            ST_HIGH: begin
                if (phase_q == 4'd0) begin
                    state_d = ST_LOW;
                    iw_d[0] = 1'b0;
                    phase_d = PHASE_INIT;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end

            ST_LOW: begin
                if (phase_q == 4'd0) begin
                    cnt_d = cnt_q - 8'd1;
                    // cnt_q == 1 means this LOW phase closes the final pulse
                    if (cnt_q != 8'd1) begin
                        state_d = ST_HIGH;
                        iw_d[0] = 1'b1;
                        phase_d = PHASE_INIT;
                    end else if (rstseq_q) begin
                        state_d = ST_RELEASE;
                        iw_d[1] = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = ow;
                    end
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end

            ST_RELEASE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ow;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                iw_d        = 18'd0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            iw_q        <= 18'd0;
            ena_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 24'd0;
            phase_q     <= 4'd0;
            cnt_q       <= 8'd0;
            rstseq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            iw_q        <= iw_d;
            ena_q       <= ena_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            rstseq_q    <= rstseq_d;
        end
    end

endmodule

// File: tb/tb_p_stim_driver.sv
// Randomized self-checking bench for p_stim_driver with a counter-style wrapper stand-in
// and a closed-form per-command reference model.
module tb_p_stim_driver;

    localparam int CH = 2;
    localparam int BUDGET = 1100;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_ENA    = 2'b10;
    localparam logic [1:0] OP_RSTSEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [16:0] cmd_data = 17'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [23:0] rsp_data;
    logic [17:0] iw;
    logic        ena;
    logic [23:0] ow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    p_stim_driver #(.CLK_HALF(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .iw        (iw),
        .ena       (ena),
        .ow        (ow)
    );

    // Wrapper stand-in: 8-bit counter clocked by iw[0], cleared while rst_n is low.
    logic       w_prev = 1'b0;
    logic [7:0] w_cnt  = 8'd0;
    int         edges  = 0;
    always @(posedge clk) begin
        w_prev <= iw[0];
        if (iw[0] && !w_prev) begin
            w_cnt <= iw[1] ? w_cnt + 8'd1 : 8'd0;
            edges <= edges + 1;
        end
    end
    assign ow = {iw[17:10], w_cnt, iw[9:2] ^ {8{ena}}};

    // Reference model state
    logic [16:0] m_iw17 = 17'd0;
    logic        m_ena  = 1'b0;
    logic [7:0]  m_cnt  = 8'd0;

    logic [17:0] iw_hist  [BUDGET+1];
    logic        ena_hist [BUDGET+1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [16:0] data, input logic [7:0] count,
                          input int hold, input bit early);
        int n, exp_lat, lat, e0, bad;
        logic [17:0] exp_iw;
        logic [23:0] exp_rsp, got;
        n = 0;
        case (op)
            OP_SET:  m_iw17 = data;
            OP_STEP: begin
                m_iw17 = data;
                n = int'(count);
                if (n > 0) m_cnt = data[0] ? m_cnt + count : 8'd0;
            end
            OP_ENA:  m_ena = data[0];
            default: begin
                m_iw17 = {data[16:1], 1'b1};
                n = int'(count);
                if (n > 0) m_cnt = 8'd0;
            end
        endcase
        exp_lat = (op == OP_RSTSEQ ? 3 : 2) + 2 * CH * n;
        exp_rsp = {m_iw17[16:9], m_cnt, m_iw17[8:1] ^ {8{m_ena}}};

        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        rsp_ready = early;
        e0 = edges;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            cmd_valid   = 1'b0;
            iw_hist[k]  = iw;
            ena_hist[k] = ena;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (lat == 0) begin
            rsp_ready = 1'b0;
            return;
        end

        bad = 0;
        for (int k = 1; k <= lat; k++) begin
            exp_iw = {m_iw17, 1'b0};
            if (op == OP_RSTSEQ && k < exp_lat - 1) exp_iw[1] = 1'b0;
            if (n > 0 && k >= 2 && k < 2 + 2 * CH * n && ((k - 2) % (2 * CH)) < CH) exp_iw[0] = 1'b1;
            if (iw_hist[k] !== exp_iw || ena_hist[k] !== m_ena) bad++;
        end
        chk("iw_wave", 32'(bad), 32'd0);
        chk("pulse_edges", 32'(edges - e0), 32'(n));
        chk("rsp_data", 32'(rsp_data), 32'(exp_rsp));

        if (early) begin
            @(negedge clk);
            chk("rsp_drop", 32'(rsp_valid), 32'd0);
            chk("ready_after", 32'(cmd_ready), 32'd1);
        end else begin
            got = rsp_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("rsp_hold", {6'd0, rsp_valid, rsp_data, cmd_ready}, {6'd0, 1'b1, got, 1'b0});
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("rsp_drop", 32'(rsp_valid), 32'd0);
            chk("ready_after", 32'(cmd_ready), 32'd1);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin : main
        logic seen;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", {5'd0, iw, ena, rsp_valid, rsp_data[7:0]}, 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;

        do_cmd(OP_RSTSEQ, 17'h1FFFF, 8'd2, 0, 1'b0);
        chk("rise_t2", 32'(iw_hist[2][0]), 32'd1);
        chk("rise_t6", 32'(iw_hist[6][0]), 32'd1);
        chk("iw1_low_t9", 32'(iw_hist[9][1]), 32'd0);
        chk("iw1_high_t10", 32'(iw_hist[10][1]), 32'd1);

        do_cmd(OP_SET, 17'h0AB55, 8'd7, 0, 1'b0);
        chk("set_iw_t1", 32'(iw_hist[1]), 32'h156AA);

        do_cmd(OP_STEP, 17'h00F01, 8'd3, 5, 1'b0);
        do_cmd(OP_ENA, 17'h00001, 8'd9, 0, 1'b1);
        chk("ena_t1", 32'(ena_hist[1]), 32'd1);
        do_cmd(OP_STEP, 17'h12345, 8'd0, 1, 1'b0);
        do_cmd(OP_RSTSEQ, 17'h0FFFF, 8'd0, 0, 1'b1);
        do_cmd(OP_STEP, 17'h1C3A1, 8'd255, 0, 1'b1);

        // Reset during the HIGH phase of a long STEP
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_STEP;
        cmd_data  = 17'h00001;
        cmd_count = 8'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_high", 32'(iw[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_iw", 32'(iw), 32'd0);
        chk("abort_ena_valid", {30'd0, ena, rsp_valid}, 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        rsp_ready = 1'b0;
        m_iw17 = 17'd0;
        m_ena  = 1'b0;
        do_cmd(OP_RSTSEQ, 17'(($urandom)), 8'd1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_op;
            logic [16:0] r_data;
            logic [7:0]  r_cnt;
            r_op   = 2'($urandom_range(0, 3));
            r_data = 17'($urandom);
            r_cnt  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(9, 20)) : 8'($urandom_range(0, 5));
            do_cmd(r_op, r_data, r_cnt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
